// File: rtl/mem_req_adapter.sv
// Upstream adapter for the Mem1R1W helper: byte-addressed valid/ready requests in,
// single-cycle r_0/w_0 strobes out, in-order responses back through a small FIFO.
module mem_req_adapter #(
    parameter int RAM_SIZE  = 64,
    parameter int RSP_DEPTH = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [63:0]          req_addr,
    input  logic [63:0]          req_wdata,
    input  logic [7:0]           req_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_write,
    output logic                 rsp_err,
    output logic                 r_0_enable,
    output logic [63:0]          r_0_index,
    input  logic [63:0]          r_0_data,
    output logic                 w_0_enable,
    output logic [63:0]          w_0_index,
    output logic [63:0]          w_0_data,
    output logic [63:0]          w_0_mask,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    // Handshakes (request and response sides): a transfer happens on the rising
    // edge where valid && ready are both high; the sender holds payload until then.

    logic [60:0]          w_index;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic [OCC_W-1:0]     w_occ;
    logic [63:0]          w_mask;
    logic [63:0]          w_push_rdata;

    logic                 r_s1_valid;
    logic                 r_s1_write;
    logic                 r_s1_err;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [63:0]          r_fifo_rdata [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] r_fifo_write;
    logic [RSP_DEPTH-1:0] r_fifo_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    assign w_index = req_addr[63:3];
    assign w_err   = (req_addr[2:0] != 3'b000) || ({3'b000, w_index} >= 64'(RAM_SIZE));

    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_s1_valid;

    // Admission counts the s1 entry so the FIFO can never overflow; the pop term
    // lets a consumed response free a slot in the same cycle.
    assign w_occ     = OCC_W'(r_count) + OCC_W'(r_s1_valid) - OCC_W'(w_pop);
    assign req_ready = reset && (w_occ < OCC_W'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_mask[i*8 +: 8] = {8{req_wstrb[i]}};
        end
    end

    always_comb begin
        r_0_enable = 1'b0;
        r_0_index  = '0;
        w_0_enable = 1'b0;
        w_0_index  = '0;
        w_0_data   = '0;
        w_0_mask   = '0;
        if (w_accept && !w_err) begin
            if (req_write) begin
                w_0_enable = 1'b1;
                w_0_index  = {3'b000, w_index};
                w_0_data   = req_wdata;
                w_0_mask   = w_mask;
            end else begin
                r_0_enable = 1'b1;
                r_0_index  = {3'b000, w_index};
            end
        end
    end

    assign w_push_rdata = (!r_s1_write && !r_s1_err) ? r_0_data : 64'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_write <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_write <= req_write;
            r_s1_err   <= w_err;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_write <= '0;
            r_fifo_err   <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_fifo_write[r_wr_ptr] <= r_s1_write;
                r_fifo_err[r_wr_ptr]   <= r_s1_err;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Read data storage needs no reset: it is only visible while rsp_valid is high.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign rsp_rdata = rsp_valid ? r_fifo_rdata[r_rd_ptr] : 64'd0;
    assign rsp_write = rsp_valid && r_fifo_write[r_rd_ptr];
    assign rsp_err   = rsp_valid && r_fifo_err[r_rd_ptr];
    assign err_count = r_err_count;

endmodule

// File: tb/tb_mem_req_adapter.sv
// Directed bench for mem_req_adapter with a behavioural Mem1R1W helper model
// and hand-computed expectations.
module tb_mem_req_adapter;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_err;
    logic        r_0_enable;
    logic [63:0] r_0_index;
    logic [63:0] r_0_data;
    logic        w_0_enable;
    logic [63:0] w_0_index;
    logic [63:0] w_0_data;
    logic [63:0] w_0_mask;
    logic [15:0] err_count;

    int n_vec;
    int n_miss;
    logic [63:0] exp_q[$];
    logic [63:0] exp_tbl [3];
    logic [63:0] mem [64];

    mem_req_adapter #(.RAM_SIZE(64), .RSP_DEPTH(2), .ERR_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_err(rsp_err),
        .r_0_enable(r_0_enable), .r_0_index(r_0_index), .r_0_data(r_0_data),
        .w_0_enable(w_0_enable), .w_0_index(w_0_index), .w_0_data(w_0_data),
        .w_0_mask(w_0_mask), .err_count(err_count)
    );

    // Clock and helper memory model (synchronous read, masked write)
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        r_0_data = 64'd0;
    end

    always @(posedge clock) begin
        if (w_0_enable) mem[w_0_index[5:0]] <= (mem[w_0_index[5:0]] & ~w_0_mask) | (w_0_data & w_0_mask);
        if (r_0_enable) r_0_data <= mem[r_0_index[5:0]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        req_valid = v;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        exp_tbl[0] = 64'h0000_0000_5566_7788;
        exp_tbl[1] = 64'hA5A5_5A5A_0F0F_F0F0;
        exp_tbl[2] = 64'hDEAD_BEEF_CAFE_F00D;
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);

        // Reset state
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_r0_en", 64'(r_0_enable), 64'd0);
        chk("rst_w0_en", 64'(w_0_enable), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Full write then read of the same word
        drive(1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        #1;
        chk("wr_w0_en", 64'(w_0_enable), 64'd1);
        chk("wr_w0_index", w_0_index, 64'd2);
        chk("wr_w0_mask", w_0_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr_w0_data", w_0_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("wr_r0_en", 64'(r_0_enable), 64'd0);
        tick();
        drive(1'b1, 1'b0, 64'h10, 64'd0, 8'd0);
        #1;
        chk("rd_r0_en", 64'(r_0_enable), 64'd1);
        chk("rd_r0_index", r_0_index, 64'd2);
        chk("rd_w0_en", 64'(w_0_enable), 64'd0);
        chk("rd_w0_mask_idle", w_0_mask, 64'd0);
        chk("wr_rsp_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        #1;
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_write", 64'(rsp_write), 64'd1);
        chk("wr_rsp_rdata", rsp_rdata, 64'd0);
        tick();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("rd_rsp_write", 64'(rsp_write), 64'd0);
        chk("rd_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        chk("drained", 64'(rsp_valid), 64'd0);

        // Partial strobe write
        drive(1'b1, 1'b1, 64'h0, 64'h1122_3344_5566_7788, 8'h0F);
        #1;
        chk("ps_w0_mask", w_0_mask, 64'h0000_0000_FFFF_FFFF);
        chk("ps_w0_index", w_0_index, 64'd0);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        #1 chk("ps_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        chk("ps_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("ps_rsp_write", 64'(rsp_write), 64'd1);
        chk("ps_rsp_rdata", rsp_rdata, 64'd0);
        tick();

        // Misaligned and out-of-range requests
        drive(1'b1, 1'b0, 64'h203, 64'd0, 8'd0);
        #1;
        chk("mis_req_ready", 64'(req_ready), 64'd1);
        chk("mis_r0_en", 64'(r_0_enable), 64'd0);
        chk("mis_w0_en", 64'(w_0_enable), 64'd0);
        tick();
        drive(1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        #1;
        chk("oor_w0_en", 64'(w_0_enable), 64'd0);
        chk("oor_w0_index", w_0_index, 64'd0);
        chk("oor_r0_en", 64'(r_0_enable), 64'd0);
        chk("err_count_1", 64'(err_count), 64'd1);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        #1;
        chk("mis_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mis_rsp_err", 64'(rsp_err), 64'd1);
        chk("mis_rsp_write", 64'(rsp_write), 64'd0);
        chk("mis_rsp_rdata", rsp_rdata, 64'd0);
        chk("err_count_2", 64'(err_count), 64'd2);
        tick();
        chk("oor_rsp_err", 64'(rsp_err), 64'd1);
        chk("oor_rsp_write", 64'(rsp_write), 64'd1);
        tick();

        // Backpressure: two accepts, then stall until responses drain
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 64'h10, 64'd0, 8'd0);
        #1 chk("bp_ready_0", 64'(req_ready), 64'd1);
        tick();
        drive(1'b1, 1'b0, 64'h0, 64'd0, 8'd0);
        #1 chk("bp_ready_1", 64'(req_ready), 64'd1);
        tick();
        drive(1'b1, 1'b1, 64'h8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        #1;
        chk("bp_ready_full", 64'(req_ready), 64'd0);
        chk("bp_w0_blocked", 64'(w_0_enable), 64'd0);
        tick();
        chk("bp_ready_hold", 64'(req_ready), 64'd0);
        chk("bp_head_valid", 64'(rsp_valid), 64'd1);
        chk("bp_head_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        chk("bp_head_stable", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("bp_ready_still0", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", 64'(req_ready), 64'd1);
        chk("bp_w0_on_pop", 64'(w_0_enable), 64'd1);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        #1;
        chk("bp_second_rdata", rsp_rdata, 64'h0000_0000_5566_7788);
        chk("bp_second_write", 64'(rsp_write), 64'd0);
        tick();
        chk("bp_third_valid", 64'(rsp_valid), 64'd1);
        chk("bp_third_write", 64'(rsp_write), 64'd1);
        tick();
        chk("bp_empty", 64'(rsp_valid), 64'd0);

        // Streaming: 10 back-to-back reads, one response per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 64'((i % 3) * 8), 64'd0, 8'd0);
            exp_q.push_back(exp_tbl[i % 3]);
            #1;
            chk("st_ready", 64'(req_ready), 64'd1);
            if (i >= 2) begin
                chk("st_valid", 64'(rsp_valid), 64'd1);
                chk("st_rdata", rsp_rdata, exp_q.pop_front());
            end
            tick();
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        for (int j = 0; j < 2; j++) begin
            #1;
            chk("st_tail_valid", 64'(rsp_valid), 64'd1);
            chk("st_tail_rdata", rsp_rdata, exp_q.pop_front());
            tick();
        end
        chk("st_done", 64'(rsp_valid), 64'd0);

        // Asynchronous reset with two responses pending
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 64'h0, 64'd0, 8'd0);
        tick();
        drive(1'b1, 1'b0, 64'h8, 64'd0, 8'd0);
        tick();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        tick();
        chk("ar_pending", 64'(rsp_valid), 64'd1);
        chk("ar_err_before", 64'(err_count), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("ar_err_count", 64'(err_count), 64'd0);
        chk("ar_req_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        #1 chk("ar_ready_back", 64'(req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_stale", 64'(rsp_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_req_adapter.md
Name: mem_req_adapter

Overview:
- Upstream request adapter for the Mem1R1WHelper port set (r_0_*/w_0_*) of the DPI memory top.
- Converts a byte-addressed valid/ready request stream (read or write, byte strobes) into single-cycle read and write port strobes.
- Captures read data one cycle later and returns in-order responses through a small response FIFO with valid/ready.
- Flags bad requests: out-of-range or misaligned addresses are rejected without touching memory.

Parameters:
- RAM_SIZE, 64, number of 64-bit words backing the helper; legal word index is 0..RAM_SIZE-1.
- RSP_DEPTH, 2, response FIFO entries; must be at least 2.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  64  byte address.
- req_wdata  input  64  write data.
- req_wstrb  input  8  byte strobes; bit i enables byte i.
- rsp_valid  output  1  response present (FIFO head).
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  output  64  read data; 0 for writes and for errors.
- rsp_write  output  1  echo of req_write.
- rsp_err  output  1  request rejected.
- r_0_enable  output  1  to helper.
- r_0_index  output  64  to helper.
- r_0_data  input  64  from helper; valid the cycle after r_0_enable.
- w_0_enable  output  1  to helper.
- w_0_index  output  64  to helper.
- w_0_data  output  64  to helper.
- w_0_mask  output  64  to helper.
- err_count  output  ERR_CNT_W  saturating count of rejected requests.

Behaviour:
- Reset (reset=0, asynchronous): s1 stage empty, FIFO empty, err_count=0. Outputs req_ready=0, rsp_valid=0, r_0_enable=0, w_0_enable=0. Data outputs are 0.
- After reset deassertion, req_ready follows the formula below from the first clock onward.
- Index and error rules:
  - index = req_addr[63:3].
  - err = (req_addr[2:0] != 0) || (index >= RAM_SIZE).
- Combinational port drive, in the same cycle as the accept:
  - Read accepted, no err: r_0_enable=1, r_0_index=index.
  - Write accepted, no err: w_0_enable=1, w_0_index=index, w_0_data=req_wdata, w_0_mask byte i = {8{req_wstrb[i]}}.
  - An errored request drives neither enable.
  - A write with req_wstrb=0 still asserts w_0_enable with an all-zero mask.
  - When not enabled, index/data/mask outputs are 0.
- Stage s1 (registered):
  - On accept, s1 captures valid, write, and err.
  - The next cycle, s1 pushes into the FIFO with rdata = r_0_data for a non-errored read, otherwise 0.
  - Fixed latency: accept at cycle N gives rsp_valid at cycle N+2 at the earliest.
- Flow control: req_ready = (fifo_count + s1_valid - pop) < RSP_DEPTH, where pop = rsp_valid && rsp_ready.
  - The combinational path from rsp_ready to req_ready is intentional.
  - It gives full throughput of one request per cycle when rsp_ready is held high.
- FIFO ordering and boundaries:
  - Strict FIFO order; a push and a pop in the same cycle are both honoured.
  - Never overflows, because admission counts s1 occupancy.
  - When the FIFO is empty, rsp_valid=0.
  - Response outputs hold stable while rsp_valid && !rsp_ready.
- err_count increments by 1 per accepted errored request and saturates at all-ones.
- Reset mid-operation: in-flight s1 and FIFO contents are discarded with no response. Memory writes already issued are not undone.
- r_0_async is not consumed by this block; reads are always treated as one-cycle synchronous.

Test Plan:
- Write then read: write addr 0x10, wdata 0xDEADBEEF_CAFEF00D, wstrb 0xFF, then read 0x10 -> w_0_index=2 and w_0_mask=all-ones on the accept cycle; read response rdata=0xDEADBEEF_CAFEF00D, err=0, two cycles after its accept.
- Partial strobe: wstrb=0x0F to addr 0x0 -> w_0_mask=0x00000000_FFFFFFFF, write response rdata=0, rsp_write=1.
- Errors: addr 0x203 (misaligned) and addr 0x200 (index 64 ≥ RAM_SIZE) -> no r_0/w_0 enable, rsp_err=1 for each, err_count=2.
- Backpressure: rsp_ready=0 with req_valid held -> exactly 2 requests accepted, then req_ready=0. Release rsp_ready -> responses drain in order, and req_ready returns the same cycle as the first pop.
- Streaming: 10 back-to-back reads with rsp_ready=1 -> req_ready stays 1 throughout, 10 in-order responses on consecutive cycles.
- Async reset asserted with 2 responses pending -> rsp_valid=0 immediately, err_count=0, no stale response after release.
